// File: rtl/synapse_loader.sv
`default_nettype none
// ============================================================================
// Module  : synapse_loader
// Purpose : Serially loads N_IN 2-bit synaptic weights over a valid/ready
//           stream, then masks them with each accepted spike vector to drive
//           the neuron adder tree (wx_out).
// Config  : WEIGHT_SHADOW_EN - double-buffered weights (load while firing)
// Revision: 1.0 - initial release
// ============================================================================
module synapse_loader #(
  parameter int N_STAGE = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_start,
  input  logic [1:0]                 weight_in,
  input  logic                       weight_valid,
  output logic                       weight_ready,
  input  logic [(2**N_STAGE)-1:0]    spikes_in,
  input  logic                       spikes_valid,
  output logic                       spikes_ready,
  output logic [2*(2**N_STAGE)-1:0]  wx_out,
  output logic                       wx_valid,
  output logic                       load_done
);

  localparam int c_n_in  = 2**N_STAGE;
  localparam int c_cnt_w = $clog2(c_n_in);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n_in - 1);

  localparam logic [0:0] c_st_load  = 1'b0;
  localparam logic [0:0] c_st_armed = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_idx;
  logic                 w_beat;
  logic                 w_last_beat;
  logic                 w_spike;
  logic [2*c_n_in-1:0]  r_weights;    // bank written by the load stream
  logic [2*c_n_in-1:0]  w_bank_next;
  logic [2*c_n_in-1:0]  w_use;        // bank seen by the spike path
  logic [2*c_n_in-1:0]  w_mask;

  assign w_beat      = weight_valid & weight_ready;
  assign w_spike     = spikes_valid & spikes_ready;
  // load_start forces the same-cycle beat to slot 0, so it can never be the last one
  assign w_last_beat = w_beat & ~load_start & (r_cnt == c_last);
  assign w_idx       = load_start ? '0 : r_cnt;

`ifdef WEIGHT_SHADOW_EN
  logic [2*c_n_in-1:0] r_active;
  logic                r_loaded;

  // Active bank snapshots the completed shadow bank (including the final beat)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= '0;
      r_loaded <= 1'b0;
    end else if (w_last_beat) begin
      r_active <= w_bank_next;
      r_loaded <= 1'b1;
    end
  end

  // Spikes always read the active bank, so a same-edge swap still sees the old weights
  assign w_use = r_active;
`else
  // Single bank: loading and firing are mutually exclusive, so no hazard exists
  assign w_use = r_weights;
`endif

  // Expand each spike bit to cover its 2-bit weight lane
  for (genvar gi = 0; gi < c_n_in; gi++) begin : g_mask
    assign w_mask[2*gi +: 2] = {2{spikes_in[gi]}};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_st_load;
    else       r_state <= w_state_next;
  end

  // Next-state logic: load_start overrides everything
  always_comb begin
    w_state_next = r_state;
    if (load_start)       w_state_next = c_st_load;
    else if (w_last_beat) w_state_next = c_st_armed;
`ifdef WEIGHT_SHADOW_EN
    else if (w_beat)      w_state_next = c_st_load;
`endif
  end

  // Handshake outputs
  always_comb begin
`ifdef WEIGHT_SHADOW_EN
    weight_ready = 1'b1;
    spikes_ready = r_loaded;
`else
    // load_start makes the cycle a LOAD cycle so its beat can land in slot 0
    weight_ready = (r_state == c_st_load) | load_start;
    spikes_ready = (r_state == c_st_armed) & ~load_start;
`endif
  end

  // Beat counter: restarts on load_start, clears after the last slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_cnt <= '0;
    else if (load_start)  r_cnt <= w_beat ? c_cnt_w'(1) : '0;
    else if (w_last_beat) r_cnt <= '0;
    else if (w_beat)      r_cnt <= r_cnt + c_cnt_w'(1);
  end

  // Merge the incoming beat into the load bank
  always_comb begin
    w_bank_next = r_weights;
    if (w_beat) w_bank_next[{w_idx, 1'b0} +: 2] = weight_in;
  end

  // Load bank register; untouched slots keep their previous weight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_weights <= '0;
    else       r_weights <= w_bank_next;
  end

  // Weighted-input register and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wx_out    <= '0;
      wx_valid  <= 1'b0;
      load_done <= 1'b0;
    end else begin
      if (w_spike) wx_out <= w_use & w_mask;
      wx_valid  <= w_spike;
      load_done <= w_last_beat;
    end
  end

endmodule
`default_nettype wire
